// File: rtl/sram_arbiter.sv
// Two-requester arbiter for an asynchronous SRAM with a single shared bus.
// Define SRAM_ARB_RR_EN for round-robin arbitration; fixed priority (requester 0) otherwise.
module sram_arbiter #(
    parameter int unsigned RD_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [17:0] addr0,
    input  logic [17:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic [1:0]  ack,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        SRAM_WE_N,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    localparam logic [3:0] LAST_RD = 4'(RD_WAIT - 1);

    state_t      state;
    logic [3:0]  rd_cnt;
    logic        grant;
    logic        pick;
    logic [15:0] wdata_q;

`ifdef SRAM_ARB_RR_EN
    logic        last;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick = (req == 2'b11) ? ~last : ~req[0];
    end
`else
    always_comb begin
        pick = ~req[0];
    end
`endif

    // The bus is driven exactly while the write strobe is low.
    assign SRAM_DQ = SRAM_WE_N ? 'z : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= 1'b0;
            rd_cnt    <= '0;
            wdata_q   <= '0;
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            SRAM_WE_N <= 1'b1;
            SRAM_ADDR <= '0;
`ifdef SRAM_ARB_RR_EN
            last      <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        grant     <= pick;
`ifdef SRAM_ARB_RR_EN
                        last      <= pick;
`endif
                        SRAM_ADDR <= pick ? addr1 : addr0;
                        wdata_q   <= pick ? wdata1 : wdata0;
                        busy      <= 1'b1;
                        rd_cnt    <= '0;
                        if (we[pick]) begin
                            state     <= WRITE;
                            SRAM_WE_N <= 1'b0;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                WRITE: begin
                    state     <= DONE;
                    SRAM_WE_N <= 1'b1;
                    ack       <= grant ? 2'b10 : 2'b01;
                end
                READ: begin
                    if (rd_cnt == LAST_RD) begin
                        rdata <= SRAM_DQ;
                        state <= DONE;
                        ack   <= grant ? 2'b10 : 2'b01;
                    end else begin
                        rd_cnt <= rd_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ack   <= '0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM bus model, directed table, corner sequences and
// randomized transactions scored against a transaction-level memory model.
module tb_sram_arbiter;

    localparam int unsigned RDW    = 2;
    localparam int          RD_LAT = RDW + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [17:0] addr0 = '0;
    logic [17:0] addr1 = '0;
    logic [15:0] wdata0 = '0;
    logic [15:0] wdata1 = '0;
    logic [1:0]  ack;
    logic [15:0] rdata;
    logic        busy;
    logic        SRAM_WE_N;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] dq;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [64];
    logic [15:0] ref_mem [64];
    logic        mem_init = 1'b1;
    logic [15:0] exp_rd;
    logic        last_win;

    always #5 clk = ~clk;

    sram_arbiter #(.RD_WAIT(RDW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .rdata(rdata), .busy(busy),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(dq)
    );

    // SRAM device: output enabled whenever it is not being written.
    assign dq = SRAM_WE_N ? mem[SRAM_ADDR[5:0]] : 'z;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'hC300 + 16'(i);
        end else if (!SRAM_WE_N) begin
            mem[SRAM_ADDR[5:0]] <= dq;
        end
    end

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [17:0] a0;
        logic [17:0] a1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        chg;
        logic [1:0]  ack;
        logic [15:0] rd;
        int          lat;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input string name, input logic [1:0] m, input logic [1:0] w,
                           input logic [17:0] a0, input logic [17:0] a1,
                           input logic [15:0] d0, input logic [15:0] d1, input logic chg,
                           input logic [1:0] exp_ack, input logic [15:0] erd, input int exp_lat);
        logic        win;
        logic [17:0] ea;
        logic [15:0] ed;
        int          cycles;
        int          wen_cnt;
        logic        got;
        logic        addr_bad;
        logic [1:0]  got_ack;
        logic        got_busy;
        win = exp_ack[1];
        ea = win ? a1 : a0;
        ed = win ? d1 : d0;
        req = m; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        cycles = 0; wen_cnt = 0; got = 1'b0; addr_bad = 1'b0;
        got_ack = '0; got_busy = 1'b0;
        while (!got && cycles < 40) begin
            @(posedge clk);
            cycles++;
            if (chg && cycles == 1) begin
                #1;
                addr0 = ~a0; addr1 = ~a1; wdata0 = ~d0; wdata1 = ~d1; we = ~w;
            end
            @(negedge clk);
            if (SRAM_ADDR !== ea) addr_bad = 1'b1;
            if (!SRAM_WE_N) begin
                wen_cnt++;
                chk($sformatf("%s_wr_dq", name), 32'(dq), 32'(ed));
            end
            if (ack != 2'b00) begin
                got = 1'b1;
                got_ack = ack;
                got_busy = busy;
            end
        end
        chk($sformatf("%s_ack_seen", name), 32'(got), 32'd1);
        chk($sformatf("%s_ack", name), 32'(got_ack), 32'(exp_ack));
        chk($sformatf("%s_latency", name), 32'(cycles), 32'(exp_lat));
        chk($sformatf("%s_we_n_cycles", name), 32'(wen_cnt), 32'(w[win] ? 1 : 0));
        chk($sformatf("%s_addr_hold", name), 32'(addr_bad), 32'd0);
        chk($sformatf("%s_busy_done", name), 32'(got_busy), 32'd1);
        chk($sformatf("%s_rdata", name), 32'(rdata), 32'(erd));
        @(posedge clk);
        #1 req = 2'b00;
        @(negedge clk);
        chk($sformatf("%s_idle", name), {ack, busy, SRAM_WE_N}, {2'b00, 1'b0, 1'b1});
        chk($sformatf("%s_idle_addr", name), 32'(SRAM_ADDR), 32'(ea));
    endtask

    initial begin
        logic [1:0]  seq [4];
        logic [1:0]  m, w, eack;
        logic [17:0] a0, a1, a;
        logic [15:0] d0, d1, erd;
        logic        win, chg, ack_seen, busy_pre;
        int          n, cyc;

        for (int i = 0; i < 64; i++) ref_mem[i] = 16'hC300 + 16'(i);

        tbl[0] = '{2'b01, 2'b11, 18'h00005, 18'h0,     16'hA5A5, 16'h0,    1'b0, 2'b01, 16'h0000, 2};
        tbl[1] = '{2'b10, 2'b00, 18'h0,     18'h00005, 16'h0,    16'h0,    1'b0, 2'b10, 16'hA5A5, RD_LAT};
        tbl[2] = '{2'b10, 2'b11, 18'h0,     18'h3FFFF, 16'h0,    16'h1234, 1'b0, 2'b10, 16'hA5A5, 2};
        tbl[3] = '{2'b01, 2'b00, 18'h3FFFF, 18'h0,     16'h0,    16'h0,    1'b0, 2'b01, 16'h1234, RD_LAT};
        tbl[4] = '{2'b01, 2'b00, 18'h00005, 18'h0,     16'h0,    16'h0,    1'b1, 2'b01, 16'hA5A5, RD_LAT};
        tbl[5] = '{2'b01, 2'b11, 18'h00009, 18'h0,     16'hFFFF, 16'h0,    1'b0, 2'b01, 16'hA5A5, 2};
        tbl[6] = '{2'b10, 2'b00, 18'h0,     18'h00009, 16'h0,    16'h0,    1'b0, 2'b10, 16'hFFFF, RD_LAT};
        tbl[7] = '{2'b10, 2'b00, 18'h0,     18'h00007, 16'h0,    16'h0,    1'b0, 2'b10, 16'hC307, RD_LAT};

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_addr", 32'(SRAM_ADDR), 32'd0);
        rst = 1'b0;
        mem_init = 1'b0;
        exp_rd = 16'h0000;
        last_win = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].a1,
                    tbl[i].d0, tbl[i].d1, tbl[i].chg, tbl[i].ack, tbl[i].rd, tbl[i].lat);
            win = tbl[i].ack[1];
            a = win ? tbl[i].a1 : tbl[i].a0;
            if (tbl[i].we[win]) ref_mem[a[5:0]] = win ? tbl[i].d1 : tbl[i].d0;
            exp_rd = tbl[i].rd;
            last_win = win;
        end

        // Reset in the middle of a read aborts it.
        req = 2'b01; we = 2'b00; addr0 = 18'h00005;
        @(posedge clk);
        #2 busy_pre = busy;
        rst = 1'b1;
        #1;
        chk("midread_was_busy", 32'(busy_pre), 32'd1);
        chk("midread_busy", 32'(busy), 32'd0);
        chk("midread_we_n", 32'(SRAM_WE_N), 32'd1);
        chk("midread_rdata", 32'(rdata), 32'd0);
        ack_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack != 2'b00) ack_seen = 1'b1;
        end
        chk("midread_no_ack", 32'(ack_seen), 32'd0);
        req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        exp_rd = 16'h0000;
        last_win = 1'b1;

        // Both requesters held high across several transactions.
        req = 2'b11; we = 2'b00; addr0 = 18'h00005; addr1 = 18'h00009;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ack != 2'b00) begin
                seq[n] = ack;
                n++;
            end
        end
        @(posedge clk);
        #1 req = 2'b00;
        chk("hold11_count", 32'(n), 32'd4);
        for (int k = 0; k < 4; k++) begin
`ifdef SRAM_ARB_RR_EN
            eack = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            eack = 2'b01;
`endif
            chk($sformatf("hold11_grant%0d", k), 32'(seq[k]), 32'(eack));
        end
`ifdef SRAM_ARB_RR_EN
        last_win = 1'b1;
`else
        last_win = 1'b0;
`endif
        exp_rd = ref_mem[last_win ? 6'd9 : 6'd5];
        @(negedge clk);
        chk("hold11_rdata", 32'(rdata), 32'(exp_rd));

        for (int i = 0; i < 40; i++) begin
            m   = 2'($urandom_range(1, 3));
            w   = 2'($urandom);
            a0  = 18'($urandom);
            a1  = 18'($urandom);
            d0  = 16'($urandom);
            d1  = 16'($urandom);
            chg = 1'($urandom);
            if (m == 2'b11) begin
`ifdef SRAM_ARB_RR_EN
                win = ~last_win;
`else
                win = 1'b0;
`endif
            end else begin
                win = (m == 2'b10);
            end
            a = win ? a1 : a0;
            erd = w[win] ? exp_rd : ref_mem[a[5:0]];
            run_txn("rnd", m, w, a0, a1, d0, d1, chg, win ? 2'b10 : 2'b01, erd,
                    w[win] ? 2 : RD_LAT);
            if (w[win]) ref_mem[a[5:0]] = win ? d1 : d0;
            exp_rd = erd;
            last_win = win;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter RD_WAIT, default 2, meaning SRAM read-access cycles before data capture (legal range 1..15).
REQ-002 The block SHALL have port clk  input  1  clock, all state changes on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port req  input  2  per-requester access request, level, bit N = requester N.
REQ-005 The block SHALL have port we  input  2  per-requester write select, 1 = write, 0 = read.
REQ-006 The block SHALL have port addr0  input  18  requester 0 word address.
REQ-007 The block SHALL have port addr1  input  18  requester 1 word address.
REQ-008 The block SHALL have port wdata0  input  16  requester 0 write data.
REQ-009 The block SHALL have port wdata1  input  16  requester 1 write data.
REQ-010 The block SHALL have port ack  output  2  one-cycle completion pulse to the granted requester.
REQ-011 The block SHALL have port rdata  output  16  read data, shared, valid when ack is high after a read.
REQ-012 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 The block SHALL have port SRAM_WE_N  output  1  SRAM write enable, active-low.
REQ-014 The block SHALL have port SRAM_ADDR  output  18  SRAM address.
REQ-015 The block SHALL have port SRAM_DQ  inout  16  SRAM data bus, driven only during WRITE, else high-Z.

Function
REQ-016 FSM states SHALL be IDLE, WRITE, READ, DONE; all outputs registered or decoded from registered state only.
REQ-017 In IDLE with any req bit high, the block SHALL grant one requester, latch its index, we, addr, wdata, and go to WRITE (we=1) or READ (we=0).
REQ-018 In IDLE with req=0, the block SHALL remain in IDLE, SRAM_WE_N=1, SRAM_DQ high-Z.
REQ-019 WRITE SHALL last exactly 1 cycle with SRAM_WE_N=0, SRAM_ADDR=latched addr, SRAM_DQ=latched wdata, then go to DONE.
REQ-020 READ SHALL last exactly RD_WAIT cycles with SRAM_WE_N=1, SRAM_DQ high-Z, SRAM_ADDR held; SRAM_DQ captured into rdata at the end of the last READ cycle; then DONE.
REQ-021 DONE SHALL last 1 cycle, assert ack[grant]=1 (other bit 0), SRAM_WE_N=1, then go to IDLE.
REQ-022 Latency from grant edge to ack: write 2 cycles (WRITE, DONE); read RD_WAIT+1 cycles.
REQ-023 Requesters SHALL hold req, we, addr, wdata until ack seen and drop req on the edge ending DONE; req still high in the following IDLE SHALL count as a new request.
REQ-024 Changes on addr/wdata/we after grant SHALL NOT affect the transaction in progress.
REQ-025 rdata SHALL hold its value until the next read capture; writes SHALL NOT modify it.
REQ-026 SRAM_ADDR SHALL hold its last value in IDLE and DONE.

Reset
REQ-027 On rst high, state SHALL go to IDLE immediately: SRAM_WE_N=1, SRAM_DQ high-Z, ack=0, rdata=0, busy=0, SRAM_ADDR=0, RR pointer=1, RD_WAIT counter=0.
REQ-028 Reset asserted during WRITE or READ SHALL abort the transaction with no ack; no SRAM write occurs after rst rises.

Configuration
REQ-029 Macro SRAM_ARB_RR_EN SHALL select arbitration policy.
REQ-030 With SRAM_ARB_RR_EN defined: round-robin; on simultaneous req, grant the requester not granted last; pointer updates at each grant; after reset requester 0 wins first.
REQ-031 Without SRAM_ARB_RR_EN: fixed priority, requester 0 always wins simultaneous requests; no pointer register.

Verification
REQ-032 Req0 write addr=0x00005, wdata=0xA5A5 -> SRAM_WE_N low exactly 1 cycle with DQ=0xA5A5, ack=2'b01 next cycle.
REQ-033 Req1 read addr=0x00005 after REQ-032, RD_WAIT=2 -> ack=2'b10 3 cycles after grant, rdata=0xA5A5, DQ never driven by block.
REQ-034 req=2'b11 held continuously with SRAM_ARB_RR_EN -> grants alternate 0,1,0,1; without macro -> grants 0,0,0.
REQ-035 rst raised mid-READ -> ack stays 0, busy=0 and SRAM_WE_N=1 immediately, rdata=0.
REQ-036 addr0 changed 0x00005 -> 0x00009 during READ -> SRAM_ADDR stays 0x00005 until DONE.
